serial_subtractor: RTL

//  Bit-serial, LSB-first subtractor: computes diff = a - b - bin over WIDTH clocks using one

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH clocks with a
// single full-subtractor cell and a borrow flop, behind a start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept_c;
  logic             last_c;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic             d_c;
  logic             borrow_nx_c;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d_c         = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_nx_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  end

  // Next-state logic; a start in DONE is accepted for back-to-back operation
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          accept_c = 1'b1;
        end
      end
      SHIFT: begin
        if (count == LAST_CNT) begin
          state_nx = DONE;
          last_c   = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nx = SHIFT;
          accept_c = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with status flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      done  <= (state_nx == DONE);
    end
  end

  // Operand capture, serial datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else if (accept_c) begin
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= '0;
      borrow  <= bin;
      count   <= '0;
    end else if (state == SHIFT) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {d_c, diff_sr[WIDTH-1:1]};
      borrow  <= borrow_nx_c;
      count   <= count + CW'(1);
      if (last_c) begin
        diff <= {d_c, diff_sr[WIDTH-1:1]};
        bout <= borrow_nx_c;
      end
    end
  end

endmodule
